// File: rtl/keysw_ctrl_pkg.sv
// keysw_ctrl_pkg: bus addresses and control-register bit positions shared by the I/O decode
package keysw_ctrl_pkg;
    localparam logic [31:0] ADDR_KDATA = 32'hF0000010;
    localparam logic [31:0] ADDR_KCTRL = 32'hF0000110;
    localparam logic [31:0] ADDR_SDATA = 32'hF0000014;
    localparam logic [31:0] ADDR_SCTRL = 32'hF0000114;
    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_IE    = 8;
endpackage

// File: rtl/keysw_ctrl_input_chan.sv
// keysw_ctrl_input_chan: sync, optional debounce, data/control registers and irq for one input device
module keysw_ctrl_input_chan
    import keysw_ctrl_pkg::*;
#(
    parameter int W          = 4,
    parameter bit DEBOUNCE   = 1'b0,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_BITS   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    input  logic         sel_data,
    input  logic         sel_ctrl,
    input  logic         wren,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         irq
);
    logic [W-1:0] s1, s2, data;
    logic         ready, ovr, ie, evt, rd_clr, ctrl_wr;
    logic [31:0]  ctrl_word;

    assign rd_clr  = sel_data & ~wren;
    assign ctrl_wr = sel_ctrl & wren;

    // two-flop synchroniser on the raw input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    generate
        if (DEBOUNCE) begin : g_deb
            logic [W-1:0]        s3;
            logic [CNT_BITS-1:0] cnt;
            logic                stable, hit;
            assign stable = (s2 == s3);
            assign hit    = (cnt == CNT_BITS'(DEB_CYCLES - 1));
            assign evt    = stable && (s2 != data) && hit;
            // count consecutive cycles the synced value is stable and differs from the data register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s3  <= '0;
                    cnt <= '0;
                end else begin
                    s3  <= s2;
                    cnt <= (!stable || s2 == data || hit) ? '0 : cnt + CNT_BITS'(1);
                end
            end
        end else begin : g_raw
            assign evt = (s2 != data);
        end
    endgenerate

    // data register, status flags and registered interrupt; a change event wins over any clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '0;
            ready <= 1'b0;
            ovr   <= 1'b0;
            ie    <= 1'b0;
            irq   <= 1'b0;
        end else begin
            data  <= evt ? s2 : data;
            ready <= evt | (ready & ~rd_clr);
            ovr   <= (evt & ready & ~rd_clr) | (ovr & ~(ctrl_wr & ~wdata[CTRL_OVR]));
            ie    <= ctrl_wr ? wdata[CTRL_IE] : ie;
            irq   <= ie & ready;
        end
    end

    // combinational read mux; zero when neither register is addressed
    always_comb begin
        ctrl_word             = '0;
        ctrl_word[CTRL_READY] = ready;
        ctrl_word[CTRL_OVR]   = ovr;
        ctrl_word[CTRL_IE]    = ie;
        rdata = (sel_data ? 32'(data) : 32'h0) | (sel_ctrl ? ctrl_word : 32'h0);
    end
endmodule

// File: rtl/keysw_ctrl.sv
// keysw_ctrl: memory-mapped key/switch input peripheral with change tracking and interrupts
module keysw_ctrl
    import keysw_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] abus,
    input  logic [31:0] dbus_in,
    input  logic        wren,
    output logic [31:0] dbus_out,
    input  logic [3:0]  key,
    input  logic [9:0]  sw,
    output logic        irq_key,
    output logic        irq_sw
);
    logic [31:0] k_rdata, s_rdata;

    keysw_ctrl_input_chan #(.W(4), .DEBOUNCE(1'b0), .DEB_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_key (
        .clk(clk), .reset(reset), .raw(~key),
        .sel_data(abus == ADDR_KDATA), .sel_ctrl(abus == ADDR_KCTRL),
        .wren(wren), .wdata(dbus_in), .rdata(k_rdata), .irq(irq_key)
    );

    keysw_ctrl_input_chan #(.W(10), .DEBOUNCE(1'b1), .DEB_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_sw (
        .clk(clk), .reset(reset), .raw(sw),
        .sel_data(abus == ADDR_SDATA), .sel_ctrl(abus == ADDR_SCTRL),
        .wren(wren), .wdata(dbus_in), .rdata(s_rdata), .irq(irq_sw)
    );

    assign dbus_out = k_rdata | s_rdata;
endmodule

// File: tb/tb_keysw_ctrl.sv
// tb_keysw_ctrl: directed self-checking bench for keysw_ctrl with a short debounce window
module tb_keysw_ctrl;
    localparam logic [31:0] KDATA = 32'hF0000010;
    localparam logic [31:0] KCTRL = 32'hF0000110;
    localparam logic [31:0] SDATA = 32'hF0000014;
    localparam logic [31:0] SCTRL = 32'hF0000114;

    logic        clk = 1'b0, reset = 1'b0, wren = 1'b0, irq_key, irq_sw;
    logic [31:0] abus = '0, dbus_in = '0, dbus_out;
    logic [3:0]  key = 4'hF;
    logic [9:0]  sw = '0;
    int          n_cmp = 0, n_err = 0;

    keysw_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_BITS(3)) dut (
        .clk(clk), .reset(reset), .abus(abus), .dbus_in(dbus_in), .wren(wren),
        .dbus_out(dbus_out), .key(key), .sw(sw), .irq_key(irq_key), .irq_sw(irq_sw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        abus = a;
        wren = 1'b0;
        #1 d = dbus_out;
        abus = '0;
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        abus = a;
        dbus_in = d;
        wren = 1'b1;
        tick(1);
        wren = 1'b0;
        abus = '0;
        dbus_in = '0;
    endtask

    initial begin
        tick(2);
        chk_rd("rst_kdata", KDATA, 32'h0);
        chk_rd("rst_kctrl", KCTRL, 32'h0);
        reset = 1'b1;
        tick(3);
        chk_rd("idle_kdata", KDATA, 32'h0);
        chk_rd("idle_kctrl", KCTRL, 32'h0);
        chk_rd("idle_sdata", SDATA, 32'h0);
        chk_rd("idle_sctrl", SCTRL, 32'h0);
        check("idle_irq", {30'h0, irq_key, irq_sw}, 32'h0);

        wr(KCTRL, 32'h100);
        key = 4'b1110;
        tick(3);
        chk_rd("k1_kdata", KDATA, 32'h1);
        chk_rd("k1_kctrl", KCTRL, 32'h101);
        check("k1_irq_lag", {31'h0, irq_key}, 32'h0);
        tick(1);
        check("k1_irq", {31'h0, irq_key}, 32'h1);
        abus = KDATA;
        #1 check("k1_rd", dbus_out, 32'h1);
        tick(1);
        abus = '0;
        chk_rd("k1_clr", KCTRL, 32'h100);
        tick(1);
        check("k1_irq_fall", {31'h0, irq_key}, 32'h0);

        key = 4'b1100;
        tick(4);
        key = 4'b1000;
        tick(4);
        chk_rd("ovr_kdata", KDATA, 32'h7);
        chk_rd("ovr_kctrl", KCTRL, 32'h105);
        wr(KCTRL, 32'h100);
        chk_rd("ovr_clr", KCTRL, 32'h101);

        key = 4'b0000;
        tick(2);
        abus = KDATA;
        tick(1);
        abus = '0;
        chk_rd("sim_kctrl", KCTRL, 32'h101);
        chk_rd("sim_kdata", KDATA, 32'hF);
        wr(KDATA, 32'hFFFFFFFF);
        chk_rd("wr_ro_kdata", KDATA, 32'hF);
        chk_rd("wr_ro_kctrl", KCTRL, 32'h101);
        chk_rd("unmapped", 32'hF0000000, 32'h0);
        chk_rd("alias", 32'h00000010, 32'h0);

        sw = 10'h3;
        tick(2);
        sw = 10'h0;
        tick(8);
        chk_rd("glitch_sdata", SDATA, 32'h0);
        chk_rd("glitch_sctrl", SCTRL, 32'h0);
        sw = 10'h3;
        tick(5);
        chk_rd("deb_early", SDATA, 32'h0);
        tick(2);
        chk_rd("deb_sdata", SDATA, 32'h3);
        chk_rd("deb_sctrl", SCTRL, 32'h1);
        check("deb_irq_sw", {31'h0, irq_sw}, 32'h0);

        check("pre_rst_irq_key", {31'h0, irq_key}, 32'h1);
        sw = 10'h5;
        tick(5);
        reset = 1'b0;
        #1;
        chk_rd("mid_rst_sctrl", SCTRL, 32'h0);
        chk_rd("mid_rst_kdata", KDATA, 32'h0);
        check("mid_rst_irq", {30'h0, irq_key, irq_sw}, 32'h0);
        tick(1);
        reset = 1'b1;
        tick(5);
        chk_rd("rerun_early", SDATA, 32'h0);
        tick(2);
        chk_rd("rerun_sdata", SDATA, 32'h5);
        chk_rd("rerun_sctrl", SCTRL, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
